fft8_controller: RTL and testbench

FFT8_CONTROLLER -- requirements
Module: fft8_controller

---
 rtl/fft8_controller.sv | 145 ++++++++++++++
 tb/tb_fft8_controller.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft8_controller.sv
// fft8_controller: in-place radix-2 DIT sequencer for an 8-point complex FFT.
// It loads samples in bit-reversed order, drives an external butterfly for 12 cycles, then unloads X[0..7] in order.
module fft8_controller (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic [31:0] bf_a,
  output logic [31:0] bf_b,
  output logic [31:0] bf_w,
  input  logic [31:0] bf_out1,
  input  logic [31:0] bf_out2,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        busy
);

  localparam int unsigned N  = 8;
  localparam int unsigned AW = 3;
  localparam int unsigned KW = 2;
  localparam int unsigned BW = 4;
  localparam int unsigned DW = 32;

  localparam logic [BW-1:0] LAST_BF = BW'(11);
  localparam logic [AW-1:0] LAST_IX = AW'(N - 1);

  localparam logic [DW-1:0] W0 = 32'h7FFF_0000;
  localparam logic [DW-1:0] W1 = 32'h5A82_A57E;
  localparam logic [DW-1:0] W2 = 32'h0000_8000;
  localparam logic [DW-1:0] W3 = 32'hA57E_A57E;

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   in_cnt_q, out_cnt_q;
  logic [BW-1:0]   bf_cnt_q;
  logic [DW-1:0]   mem [N];
  logic [AW-1:0]   top, bot;
  logic [KW-1:0]   kw;
  logic [DW-1:0]   twiddle;
  logic            in_fire, out_fire, bf_fire;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] n);
    return {n[0], n[1], n[2]};
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= LOAD;
    else          state_q <= state_d;
  end

  // Next state and handshake decode
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    in_fire   = 1'b0;
    out_fire  = 1'b0;
    bf_fire   = 1'b0;
    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        in_fire  = in_valid;
        if (in_valid && (in_cnt_q == LAST_IX)) state_d = COMPUTE;
      end
      COMPUTE: begin
        busy    = 1'b1;
        bf_fire = 1'b1;
        if (bf_cnt_q == LAST_BF) state_d = UNLOAD;
      end
      UNLOAD: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_fire  = out_ready;
        if (out_ready && (out_cnt_q == LAST_IX)) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  // Sample, butterfly and output counters; 3-bit counters wrap to 0 at frame end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      in_cnt_q  <= '0;
      bf_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      if (in_fire)  in_cnt_q  <= in_cnt_q + AW'(1);
      if (bf_fire)  bf_cnt_q  <= (bf_cnt_q == LAST_BF) ? '0 : bf_cnt_q + BW'(1);
      if (out_fire) out_cnt_q <= out_cnt_q + AW'(1);
    end
  end

  // bf_cnt = {stage, j}; bottom index is top with the stage's half bit set
  always_comb begin
    top = '0;
    bot = '0;
    kw  = '0;
    case (bf_cnt_q[3:2])
      2'd0: begin
        top = {bf_cnt_q[1:0], 1'b0};
        bot = top | AW'(1);
      end
      2'd1: begin
        top = {bf_cnt_q[1], 1'b0, bf_cnt_q[0]};
        bot = top | AW'(2);
        kw  = {bf_cnt_q[0], 1'b0};
      end
      2'd2: begin
        top = {1'b0, bf_cnt_q[1:0]};
        bot = top | AW'(4);
        kw  = bf_cnt_q[1:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    case (kw)
      2'd0:    twiddle = W0;
      2'd1:    twiddle = W1;
      2'd2:    twiddle = W2;
      default: twiddle = W3;
    endcase
  end

  assign bf_a     = bf_fire   ? mem[top]       : '0;
  assign bf_b     = bf_fire   ? mem[bot]       : '0;
  assign bf_w     = bf_fire   ? twiddle        : '0;
  assign out_data = out_valid ? mem[out_cnt_q] : '0;

  // Sample storage: no reset, contents are meaningless until a frame is loaded
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem[bitrev(in_cnt_q)] <= in_data;
    end else if (bf_fire) begin
      mem[top] <= bf_out1;
      mem[bot] <= bf_out2;
    end
  end

endmodule

// File: tb/tb_fft8_controller.sv
// Bench for fft8_controller: a rounding Q1.15 butterfly closes the loop; results are checked against
// a spec-table address model and a floating-point 8-point DFT.
`timescale 1ns/1ps
module tb_fft8_controller;

  logic        clk = 1'b0;
  logic        reset_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] in_data, bf_a, bf_b, bf_w, bf_out1, bf_out2, out_data;

  int errors = 0;
  int checks = 0;

  logic [31:0] xin  [8];
  logic [31:0] yout [8];
  logic [31:0] mdl  [8];

  int          tops [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int          bots [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int          kidx [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
  logic [31:0] wtab [4]  = '{32'h7FFF_0000, 32'h5A82_A57E, 32'h0000_8000, 32'hA57E_A57E};

  localparam real PI = 3.14159265358979323846;

  always #5 clk = ~clk;

  fft8_controller dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .bf_a     (bf_a),
    .bf_b     (bf_b),
    .bf_w     (bf_w),
    .bf_out1  (bf_out1),
    .bf_out2  (bf_out2),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .busy     (busy)
  );

  function automatic int s16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  // w*b in Q1.15, rounded to nearest, wrapped to 16 bits per component
  function automatic logic [31:0] mulw(input logic [31:0] b, input logic [31:0] w);
    longint pr, pi;
    pr = longint'(s16(w[31:16])) * longint'(s16(b[31:16])) - longint'(s16(w[15:0])) * longint'(s16(b[15:0]));
    pi = longint'(s16(w[31:16])) * longint'(s16(b[15:0])) + longint'(s16(w[15:0])) * longint'(s16(b[31:16]));
    pr = (pr + 64'sd16384) >>> 15;
    pi = (pi + 64'sd16384) >>> 15;
    return {pr[15:0], pi[15:0]};
  endfunction

  function automatic logic [31:0] cadd(input logic [31:0] a, input logic [31:0] t);
    return {16'(a[31:16] + t[31:16]), 16'(a[15:0] + t[15:0])};
  endfunction

  function automatic logic [31:0] csub(input logic [31:0] a, input logic [31:0] t);
    return {16'(a[31:16] - t[31:16]), 16'(a[15:0] - t[15:0])};
  endfunction

  function automatic int brev(input int n);
    return ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
  endfunction

  assign bf_out1 = cadd(bf_a, mulw(bf_b, bf_w));
  assign bf_out2 = csub(bf_a, mulw(bf_b, bf_w));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input logic [15:0] obs, input real exp);
    real d;
    bit  ok;
    checks++;
    d  = $itor(s16(obs)) - exp;
    ok = (d <= 3.0) && (d >= -3.0);
    assert (ok) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0.3f (+-3)", tag, s16(obs), exp);
    end
  endtask

  task automatic load_frame();
    for (int n = 0; n < 8; n++) begin
      while ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        chk("load_idle_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        in_data  = $urandom;
      end
      @(negedge clk);
      chk("load_in_ready", 32'(in_ready), 32'd1);
      chk("load_busy", 32'(busy), 32'd0);
      chk("load_bf_a_zero", bf_a, 32'h0);
      in_valid = 1'b1;
      in_data  = xin[n];
      mdl[brev(n)] = xin[n];
    end
  endtask

  // Checks addressing each cycle and advances the reference memory; abort_at >= 0 pulses reset there
  task automatic compute_phase(input int abort_at);
    logic [31:0] a, b, w;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      chk("cmp_busy", 32'(busy), 32'd1);
      chk("cmp_in_ready", 32'(in_ready), 32'd0);
      chk("cmp_out_valid", 32'(out_valid), 32'd0);
      chk($sformatf("cmp_bf_a_%0d", c), bf_a, mdl[tops[c]]);
      chk($sformatf("cmp_bf_b_%0d", c), bf_b, mdl[bots[c]]);
      chk($sformatf("cmp_bf_w_%0d", c), bf_w, wtab[kidx[c]]);
      if (c == abort_at) begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_bf_a", bf_a, 32'h0);
        chk("rst_bf_w", bf_w, 32'h0);
        return;
      end
      a = mdl[tops[c]];
      b = mdl[bots[c]];
      w = wtab[kidx[c]];
      mdl[tops[c]] = cadd(a, mulw(b, w));
      mdl[bots[c]] = csub(a, mulw(b, w));
    end
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready
  task automatic unload_phase(input int mode);
    int   k = 0;
    int   p = 0;
    logic rdy;
    for (int cyc = 0; cyc < 64 && k < 8; cyc++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      chk("unl_out_valid", 32'(out_valid), 32'd1);
      chk("unl_in_ready", 32'(in_ready), 32'd0);
      chk("unl_busy", 32'(busy), 32'd1);
      chk($sformatf("unl_data_%0d", k), out_data, mdl[k]);
      if (mode == 0)      rdy = 1'b1;
      else if (mode == 1) rdy = ((p % 3) == 0);
      else                rdy = 1'($urandom_range(0, 1));
      p++;
      out_ready = rdy;
      if (rdy) begin
        yout[k] = out_data;
        k++;
      end
    end
    chk("unl_count", 32'(k), 32'd8);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'($urandom_range(0, 1));
    chk("post_in_ready", 32'(in_ready), 32'd1);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_out_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic dft_check(input string tag, input bit skip0);
    real sr, si, xr, xi, ang;
    for (int k = 0; k < 8; k++) begin
      sr = 0.0;
      si = 0.0;
      for (int n = 0; n < 8; n++) begin
        xr  = $itor(s16(xin[n][31:16]));
        xi  = $itor(s16(xin[n][15:0]));
        ang = -2.0 * PI * $itor(k * n) / 8.0;
        sr  = sr + xr * $cos(ang) - xi * $sin(ang);
        si  = si + xr * $sin(ang) + xi * $cos(ang);
      end
      if (!(skip0 && k == 0)) begin
        chk_tol($sformatf("%s_re%0d", tag, k), yout[k][31:16], sr);
        chk_tol($sformatf("%s_im%0d", tag, k), yout[k][15:0], si);
      end
    end
  endtask

  task automatic gen_random();
    for (int n = 0; n < 8; n++) begin
      xin[n] = {16'(int'($urandom_range(0, 2046)) - 1023), 16'(int'($urandom_range(0, 2046)) - 1023)};
    end
  endtask

  task automatic impulse_frame(input string tag);
    xin = '{32'h4000_0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    load_frame();
    compute_phase(-1);
    unload_phase(0);
    for (int k = 0; k < 8; k++) chk($sformatf("%s_%0d", tag, k), yout[k], 32'h4000_0000);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_bf_a", bf_a, 32'h0);
    chk("reset_bf_b", bf_b, 32'h0);
    chk("reset_bf_w", bf_w, 32'h0);
    reset_n = 1'b1;

    impulse_frame("impulse");

    for (int n = 0; n < 8; n++) xin[n] = 32'h1000_0000;
    load_frame();
    compute_phase(-1);
    unload_phase(2);
    chk("const_x0", yout[0], 32'h8000_0000);
    dft_check("const", 1'b1);

    for (int f = 0; f < 3; f++) begin
      gen_random();
      load_frame();
      compute_phase(-1);
      unload_phase(f);
      dft_check($sformatf("rand%0d", f), 1'b0);
    end

    gen_random();
    load_frame();
    compute_phase(5);
    impulse_frame("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
